sparce_mem_req_aligner: RTL and testbench
=========================================

Name: sparce_mem_req_aligner

Overview:
- Request front-end that sits directly upstream of the sparse memory array.
- Accepts byte/half/word/dword load-store requests at arbitrary byte addresses, typed by the package `mem_op_e`.
- Converts each request into one or two DATA_WIDTH-aligned memory beats with byte enables.
- Merges split read data and returns a right-justified, zero-extended response.
- One request in flight at a time.

Parameters:
- ADDR_WIDTH, default 32: byte address width; minimum 32.
- DATA_WIDTH, default 32: memory word width, 32 or 64. BC = DATA_WIDTH/8; BADDR = log2(BC).

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  2  mem_op_e: BYTE_OP, HALF_OP, WORD_OP, DWORD_OP (DATA_WIDTH 64 only); any other encoding is NOP.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address, any alignment.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- mem_valid  out  1  memory beat valid.
- mem_ready  in  1  memory accepts beat.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_WIDTH  aligned address; low BADDR bits always 0.
- mem_be  out  BC  byte enables.
- mem_wdata  out  DATA_WIDTH  lane-positioned write data.
- mem_rvalid  in  1  read data return, in order, for the last accepted read beat.
- mem_rdata  in  DATA_WIDTH  read data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  load result, zero-extended; 0 for stores and NOP.

Behaviour:
- Reset values: req_ready=1; mem_valid, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid, rsp_rdata all 0. FSM goes to IDLE.
- Reset mid-operation abandons the request; no further beats are issued. An mem_rvalid arriving after reset deassert while in IDLE is ignored.
- Size S bytes = 1, 2, 4, 8 for BYTE, HALF, WORD, DWORD. Offset OFF = req_addr[BADDR-1:0]. A request is split when OFF+S > BC.
- Request is accepted on req_valid & req_ready. All request fields are captured; req_ready drops the next cycle and stays 0 until the cycle after rsp_valid.
- FSM states: IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP.
  - IDLE: on accept go to BEAT0. NOP goes straight to RESP with no memory traffic.
  - BEAT0:
    - mem_valid=1; mem_addr = addr with low BADDR bits cleared.
    - mem_be = ((1<<S)-1) << OFF, truncated to BC bits.
    - mem_wdata = wdata << (8*OFF).
    - On mem_ready: read goes to WAIT0; write goes to BEAT1 if split, else RESP.
  - WAIT0: on mem_rvalid capture rdata as lo; go to BEAT1 if split, else RESP.
  - BEAT1:
    - mem_addr = aligned addr + BC, wrapping modulo 2^ADDR_WIDTH.
    - mem_be = ((1<<S)-1) >> (BC-OFF).
    - mem_wdata = wdata >> (8*(BC-OFF)).
    - On mem_ready: read goes to WAIT1; write goes to RESP.
  - WAIT1: on mem_rvalid capture rdata as hi; go to RESP.
  - RESP:
    - rsp_valid=1 for exactly one cycle.
    - Load: rsp_rdata = ((lo >> 8*OFF) | (hi << 8*(BC-OFF))) masked to S bytes; hi = 0 if not split.
    - Store/NOP: rsp_rdata = 0.
    - Go to IDLE.
- mem_valid and all mem_* fields are held stable while mem_valid=1 and mem_ready=0. mem_valid=0 outside BEAT0/BEAT1.
- Latency, with mem_ready=1 and read return latency L:
  - aligned store: rsp_valid 2 cycles after accept.
  - split store: 3 cycles after accept.
  - aligned load: 2+L cycles after accept.
  - split load: 3+2L cycles after accept.
  - NOP: 1 cycle after accept.
- mem_rvalid outside WAIT0/WAIT1 is ignored.

Test Plan (DATA_WIDTH=32):
1. WORD store, addr 0x100, wdata 0xDEADBEEF -> one beat: addr 0x100, be 4'b1111, wdata 0xDEADBEEF; rsp_valid pulse, rsp_rdata 0.
2. HALF store, addr 0x103, wdata 0x0000ABCD:
   - beat0: addr 0x100, be 4'b1000, wdata 0xCD000000.
   - beat1: addr 0x104, be 4'b0001, wdata 0x000000AB.
3. WORD load, addr 0x202; memory returns 0x44332211 for 0x200 and 0x88776655 for 0x204 -> two read beats; rsp_rdata 0x66554433.
4. BYTE load, addr 0x7; memory returns 0xAABBCCDD for 0x4 -> single beat, be 4'b1000; rsp_rdata 0x000000AA. Repeat with mem_ready held low 3 cycles -> mem_* fields stable throughout.
5. WORD store, addr 0xFFFFFFFE -> beat0: addr 0xFFFFFFFC, be 4'b1100; beat1: addr 0x00000000, be 4'b0011 (address wraps).
6. NOP (req_op=3) -> no mem_valid, rsp_valid 1 cycle after accept. Split load with rst asserted in WAIT1 -> all outputs at reset values; req_ready=1 after release; late mem_rvalid produces no rsp_valid.

Source files
------------

// File: rtl/sparce_mem_req_aligner.sv
// rtl/sparce_mem_req_aligner.sv - splits unaligned load/store requests into aligned memory beats
// and merges split read data into a right-justified, zero-extended response.
package sparce_mem_req_aligner_pkg;
  typedef enum logic [1:0] {
    BYTE_OP  = 2'd0,
    HALF_OP  = 2'd1,
    WORD_OP  = 2'd2,
    DWORD_OP = 2'd3
  } mem_op_e;
endpackage

module sparce_mem_req_aligner
  import sparce_mem_req_aligner_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata
);
  localparam int BC    = DATA_WIDTH / 8;
  localparam int BADDR = $clog2(BC);

  typedef enum logic [2:0] {IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP} state_e;

  function automatic logic [BC-1:0] size_mask(input logic [1:0] op);
    case (mem_op_e'(op))
      BYTE_OP:  size_mask = BC'(1);
      HALF_OP:  size_mask = BC'(3);
      WORD_OP:  size_mask = BC'(15);
      DWORD_OP: size_mask = '1;
    endcase
  endfunction

  function automatic logic is_nop(input logic [1:0] op);
    is_nop = (op == 2'd3) && (DATA_WIDTH != 64);
  endfunction

  // Two-beat wide views: low half lands in beat 0, high half spills into beat 1.
  function automatic logic [2*BC-1:0] be_full(input logic [BADDR-1:0] off, input logic [BC-1:0] m);
    logic [2*BC-1:0] t;
    t = {{BC{1'b0}}, m};
    be_full = t << off;
  endfunction

  function automatic logic [2*DATA_WIDTH-1:0] wd_full(input logic [BADDR-1:0] off,
                                                     input logic [DATA_WIDTH-1:0] d);
    logic [2*DATA_WIDTH-1:0] t;
    t = {{DATA_WIDTH{1'b0}}, d};
    wd_full = t << {off, 3'b000};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] byte_expand(input logic [BC-1:0] m);
    for (int i = 0; i < BC; i++) byte_expand[8*i +: 8] = {8{m[i]}};
  endfunction

  state_e                  state_q;
  logic                    req_ready_q, split_q;
  logic [BC-1:0]           mask_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, lo_q;
  logic                    mem_valid_q, mem_we_q, rsp_valid_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [BC-1:0]           mem_be_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, rsp_rdata_q;

  logic [BADDR-1:0]        req_off, cur_off;
  logic [BC-1:0]           req_mask, b1_be;
  logic                    req_split;
  logic [ADDR_WIDTH-1:0]   b1_addr;
  logic [DATA_WIDTH-1:0]   b1_wdata, rd_lo, rd_hi, rd_result;

  assign req_off   = req_addr[BADDR-1:0];
  assign req_mask  = size_mask(req_op);
  assign req_split = (be_full(req_off, req_mask) >> BC) != '0;
  assign cur_off   = addr_q[BADDR-1:0];
  assign b1_addr   = {addr_q[ADDR_WIDTH-1:BADDR], {BADDR{1'b0}}} + ADDR_WIDTH'(BC);
  assign b1_be     = BC'(be_full(cur_off, mask_q) >> BC);
  assign b1_wdata  = DATA_WIDTH'(wd_full(cur_off, wdata_q) >> DATA_WIDTH);
  assign rd_lo     = (state_q == WAIT1) ? lo_q : mem_rdata;
  assign rd_hi     = (state_q == WAIT1) ? mem_rdata : '0;
  assign rd_result = DATA_WIDTH'({rd_hi, rd_lo} >> {cur_off, 3'b000}) & byte_expand(mask_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      split_q     <= 1'b0;
      mask_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (req_valid && req_ready_q) begin
          req_ready_q <= 1'b0;
          split_q     <= req_split;
          mask_q      <= req_mask;
          addr_q      <= req_addr;
          wdata_q     <= req_wdata;
          mem_we_q    <= req_we;
          if (is_nop(req_op)) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            state_q     <= BEAT0;
            mem_valid_q <= 1'b1;
            mem_addr_q  <= {req_addr[ADDR_WIDTH-1:BADDR], {BADDR{1'b0}}};
            mem_be_q    <= BC'(be_full(req_off, req_mask));
            mem_wdata_q <= DATA_WIDTH'(wd_full(req_off, req_wdata));
          end
        end
        BEAT0: if (mem_ready) begin
          if (!mem_we_q) begin
            state_q     <= WAIT0;
            mem_valid_q <= 1'b0;
          end else if (split_q) begin
            state_q     <= BEAT1;
            mem_addr_q  <= b1_addr;
            mem_be_q    <= b1_be;
            mem_wdata_q <= b1_wdata;
          end else begin
            state_q     <= RESP;
            mem_valid_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
          end
        end
        WAIT0: if (mem_rvalid) begin
          if (split_q) begin
            lo_q        <= mem_rdata;
            state_q     <= BEAT1;
            mem_valid_q <= 1'b1;
            mem_addr_q  <= b1_addr;
            mem_be_q    <= b1_be;
            mem_wdata_q <= b1_wdata;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rd_result;
          end
        end
        BEAT1: if (mem_ready) begin
          mem_valid_q <= 1'b0;
          if (!mem_we_q) begin
            state_q <= WAIT1;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
          end
        end
        WAIT1: if (mem_rvalid) begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= rd_result;
        end
        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_sparce_mem_req_aligner.sv
// tb/tb_sparce_mem_req_aligner.sv - directed and randomized check of the request aligner
// against a byte-level reference model.
module tb_sparce_mem_req_aligner;
  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [1:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  sparce_mem_req_aligner #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
  );

  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; } beat_t;
  beat_t       exp_beats[$];
  logic [31:0] exp_rsp[$];
  logic [31:0] mem [logic [31:0]];
  beat_t       cb;

  int total = 0, bad = 0, cyc = 0;
  int rsp_cnt = 0, rsp_cyc = 0, beats_done = 0, log_n = 0;
  logic [31:0] last_rsp;
  logic [31:0] log_addr [4];
  logic [3:0]  log_be [4];
  logic [31:0] log_wd [4];
  int lat_L = 1, ready_mode = 0, stall_n = 0, rd_cnt = 0;
  bit spur = 0, rd_pending = 0;
  logic [31:0] rd_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'hC3A55A3C;
  endfunction

  // Byte-by-byte view: byte i of the request lives at address addr+i.
  task automatic model_req(input logic [1:0] op, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, output int nb);
    beat_t       bl [2];
    logic [31:0] rsp, ba, wa, word;
    int          s, lane;
    s   = (op == 2'd0) ? 1 : (op == 2'd1) ? 2 : (op == 2'd2) ? 4 : 0;
    nb  = 0;
    rsp = '0;
    for (int i = 0; i < s; i++) begin
      ba   = addr + 32'(i);
      wa   = {ba[31:2], 2'b00};
      lane = int'(ba[1:0]);
      if (nb == 0 || bl[nb-1].addr != wa) begin
        bl[nb] = '{we: we, addr: wa, be: 4'b0, wd: 32'b0};
        nb++;
      end
      bl[nb-1].be[lane]         = 1'b1;
      bl[nb-1].wd[lane*8 +: 8]  = wd[i*8 +: 8];
      word                      = mem_rd(wa);
      rsp[i*8 +: 8]             = word[lane*8 +: 8];
    end
    for (int k = 0; k < nb; k++) exp_beats.push_back(bl[k]);
    exp_rsp.push_back(we ? 32'b0 : rsp);
  endtask

  // Compare process: every cycle out of reset, beats and responses against the model queues.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (mem_valid === 1'b1) begin
        if (exp_beats.size() == 0) begin
          fail("unexpected_beat");
        end else begin
          cb = exp_beats[0];
          chk("beat_we", 32'(mem_we), 32'(cb.we));
          chk("beat_addr", mem_addr, cb.addr);
          chk("beat_be", 32'(mem_be), 32'(cb.be));
          if (cb.we) chk("beat_wdata", mem_wdata & {{8{cb.be[3]}}, {8{cb.be[2]}}, {8{cb.be[1]}}, {8{cb.be[0]}}}, cb.wd);
          if (mem_ready === 1'b1) begin
            void'(exp_beats.pop_front());
            if (log_n < 4) begin
              log_addr[log_n] = mem_addr;
              log_be[log_n]   = mem_be;
              log_wd[log_n]   = mem_wdata;
            end
            log_n++;
            beats_done++;
            if (!cb.we) begin
              rd_pending = 1'b1;
              rd_addr    = cb.addr;
              rd_cnt     = lat_L;
            end
          end
        end
      end
      if (rsp_valid === 1'b1) begin
        if (exp_rsp.size() == 0) fail("unexpected_rsp");
        else chk("rsp_rdata", rsp_rdata, exp_rsp.pop_front());
        rsp_cnt++;
        rsp_cyc  = cyc;
        last_rsp = rsp_rdata;
      end
    end
  end

  // Memory responder: read data after lat_L cycles, ready per mode, stray rvalids when idle.
  always @(posedge clk) begin
    #1;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (rd_pending) begin
      rd_cnt--;
      if (rd_cnt <= 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_rd(rd_addr);
        rd_pending = 1'b0;
      end
    end else if (spur && ($urandom % 4 == 0)) begin
      mem_rvalid = 1'b1;
    end
    if (stall_n > 0 && mem_valid === 1'b1) begin
      mem_ready = 1'b0;
      stall_n--;
    end else if (ready_mode == 0) begin
      mem_ready = 1'b1;
    end else begin
      mem_ready = 1'($urandom % 2);
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_be"}, 32'(mem_be), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the response.
  task automatic issue(input logic [1:0] op, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, output int lat, output int nb);
    int n, rc0, acc;
    n = 0;
    lat = -1;
    while (req_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (req_ready !== 1'b1) begin fail("req_ready_timeout"); return; end
    log_n = 0;
    rc0 = rsp_cnt;
    model_req(op, we, addr, wd, nb);
    req_valid = 1'b1; req_op = op; req_we = we; req_addr = addr; req_wdata = wd;
    acc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 2'($urandom); req_we = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    chk("req_ready_drop", 32'(req_ready), 32'd0);
    n = 0;
    while (rsp_cnt == rc0 && n < 300) begin @(posedge clk); #1; n++; end
    if (rsp_cnt == rc0) begin fail("rsp_timeout"); return; end
    lat = rsp_cyc - acc;
    chk("req_ready_back", 32'(req_ready), 32'd1);
    chk("beats_left", 32'(exp_beats.size()), 32'd0);
  endtask

  initial begin
    int lat, nb, n, rc0, b0, e;
    logic [1:0]  op;
    logic        we;
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    mem[32'h200] = 32'h44332211;
    mem[32'h204] = 32'h88776655;
    mem[32'h004] = 32'hAABBCCDD;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1 rst = 1'b0;

    issue(2'd2, 1'b1, 32'h100, 32'hDEADBEEF, lat, nb);
    chk("t1_lat", 32'(lat), 32'd2);
    chk("t1_nbeats", 32'(log_n), 32'd1);
    chk("t1_addr", log_addr[0], 32'h100);
    chk("t1_be", 32'(log_be[0]), 32'hF);
    chk("t1_wdata", log_wd[0], 32'hDEADBEEF);
    chk("t1_rsp", last_rsp, 32'h0);

    issue(2'd1, 1'b1, 32'h103, 32'h0000ABCD, lat, nb);
    chk("t2_lat", 32'(lat), 32'd3);
    chk("t2_addr0", log_addr[0], 32'h100);
    chk("t2_be0", 32'(log_be[0]), 32'h8);
    chk("t2_wdata0", log_wd[0], 32'hCD000000);
    chk("t2_addr1", log_addr[1], 32'h104);
    chk("t2_be1", 32'(log_be[1]), 32'h1);
    chk("t2_wdata1", log_wd[1], 32'h000000AB);

    lat_L = 2;
    issue(2'd2, 1'b0, 32'h202, 32'h0, lat, nb);
    chk("t3_lat", 32'(lat), 32'd7);
    chk("t3_nbeats", 32'(log_n), 32'd2);
    chk("t3_rsp", last_rsp, 32'h66554433);

    lat_L = 1;
    issue(2'd0, 1'b0, 32'h7, 32'h0, lat, nb);
    chk("t4_lat", 32'(lat), 32'd3);
    chk("t4_be", 32'(log_be[0]), 32'h8);
    chk("t4_rsp", last_rsp, 32'h000000AA);
    stall_n = 3;
    issue(2'd0, 1'b0, 32'h7, 32'h0, lat, nb);
    chk("t4s_stall_used", 32'(stall_n), 32'd0);
    chk("t4s_nbeats", 32'(log_n), 32'd1);
    chk("t4s_rsp", last_rsp, 32'h000000AA);

    issue(2'd2, 1'b1, 32'hFFFFFFFE, 32'h12345678, lat, nb);
    chk("t5_addr0", log_addr[0], 32'hFFFFFFFC);
    chk("t5_be0", 32'(log_be[0]), 32'hC);
    chk("t5_addr1", log_addr[1], 32'h0);
    chk("t5_be1", 32'(log_be[1]), 32'h3);

    issue(2'd3, 1'b0, 32'h40, 32'h0, lat, nb);
    chk("t6_nop_lat", 32'(lat), 32'd1);
    chk("t6_nop_nbeats", 32'(log_n), 32'd0);
    chk("t6_nop_rsp", last_rsp, 32'h0);

    // Split load, reset while waiting for the second read return.
    lat_L = 5;
    b0 = beats_done;
    model_req(2'd2, 1'b0, 32'h302, 32'h0, nb);
    req_valid = 1'b1; req_op = 2'd2; req_we = 1'b0; req_addr = 32'h302; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (beats_done < b0 + 2 && n < 100) begin @(posedge clk); #1; n++; end
    if (beats_done < b0 + 2) fail("t6_wait1_timeout");
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("t6_rst");
    exp_beats.delete();
    exp_rsp.delete();
    @(posedge clk); #1 rst = 1'b0;
    chk("t6_ready_after_rst", 32'(req_ready), 32'd1);
    rc0 = rsp_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_no_late_rsp", 32'(rsp_cnt), 32'(rc0));
    chk("t6_late_rvalid_sent", 32'(rd_pending), 32'd0);

    spur = 1'b1;
    for (int r = 0; r < 200; r++) begin
      op = 2'($urandom);
      we = 1'($urandom);
      case ($urandom % 4)
        0: a = $urandom;
        1: a = 32'hFFFFFFFC | 32'($urandom % 4);
        2: a = 32'h1000 + 32'($urandom % 16);
        default: a = {$urandom} & 32'h0000_FFFF;
      endcase
      ready_mode = int'($urandom % 2);
      lat_L = 1 + int'($urandom % 3);
      issue(op, we, a, $urandom, lat, nb);
      if (ready_mode == 0) begin
        if (op == 2'd3) e = 1;
        else if (we) e = (nb == 2) ? 3 : 2;
        else e = (nb == 2) ? 3 + 2 * lat_L : 2 + lat_L;
        chk("rand_latency", 32'(lat), 32'(e));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
